regfile_load_unit: RTL and testbench



---
 rtl/regfile_load_unit.sv | 169 ++++++++++++++++
 tb/tb_regfile_load_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_load_unit.sv
// ---------------------------------------------------------------------------
// regfile_load_unit
// Write-side master for the 8x16 register file that executes LOAD
// (Op1 <- RAM[Op2]). It takes one command over valid/ready, issues a single
// RAM read, waits the fixed RAM latency and then writes the returned word
// into the register file for one cycle. Only one load is in flight at a time.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       load command handshake
//   cmd_dest, cmd_addr        destination register, RAM address
//   mem_re, mem_addr          RAM read strobe and address (registered)
//   mem_rdata                 RAM read data, valid MEM_LAT cycles after mem_re
//   write_enable/addr/data    register file write port (registered)
//   busy_mask                 one-hot pending-destination mask
//
// Configuration macro
//   LOAD_SCOREBOARD_EN  when defined, busy_mask flags the destination of the
//                       in-flight load; otherwise busy_mask is tied to 0.
// ---------------------------------------------------------------------------
module regfile_load_unit #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_ADDR_W = 3,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned MEM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [REG_ADDR_W-1:0] cmd_dest,
   input  logic [ADDR_W-1:0]     cmd_addr,
   output logic                  mem_re,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  write_enable,
   output logic [REG_ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0]     write_data,
   output logic [7:0]            busy_mask
);

   // Wait counter holds MEM_LAT-1, MEM_LAT is at most 15.
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   mem_re_q, mem_re_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic                   write_enable_q, write_enable_d;
   logic [REG_ADDR_W-1:0]  write_addr_q, write_addr_d;
   logic [DATA_W-1:0]      write_data_q, write_data_d;
   logic [REG_ADDR_W-1:0]  dest_q, dest_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cmd_ready_q    <= 1'b1;
         mem_re_q       <= 1'b0;
         mem_addr_q     <= '0;
         write_enable_q <= 1'b0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         dest_q         <= '0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         cmd_ready_q    <= cmd_ready_d;
         mem_re_q       <= mem_re_d;
         mem_addr_q     <= mem_addr_d;
         write_enable_q <= write_enable_d;
         write_addr_q   <= write_addr_d;
         write_data_q   <= write_data_d;
         dest_q         <= dest_d;
         cnt_q          <= cnt_d;
      end
   end

   // Next state; outputs are computed one cycle ahead so every port is a flop.
   // mem_addr_q doubles as the latched RAM address, write_data_q as the
   // captured read data.
   always_comb begin
      state_d        = state_q;
      cmd_ready_d    = cmd_ready_q;
      mem_re_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      write_enable_d = 1'b0;
      write_addr_d   = write_addr_q;
      write_data_d   = write_data_q;
      dest_d         = dest_q;
      cnt_d          = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               dest_d      = cmd_dest;
               mem_addr_d  = cmd_addr;
               mem_re_d    = 1'b1;
               cmd_ready_d = 1'b0;
               state_d     = ST_READ;
            end
         end
         ST_READ: begin
            cnt_d   = CNT_W'(MEM_LAT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               write_enable_d = 1'b1;
               write_addr_d   = dest_q;
               write_data_d   = mem_rdata;
               state_d        = ST_WRITE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WRITE: begin
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   assign cmd_ready    = cmd_ready_q;
   assign mem_re       = mem_re_q;
   assign mem_addr     = mem_addr_q;
   assign write_enable = write_enable_q;
   assign write_addr   = write_addr_q;
   assign write_data   = write_data_q;

`ifdef LOAD_SCOREBOARD_EN
   logic [7:0] busy_q, busy_d;

   // Destination is pending from the cycle after accept through the WRITE cycle.
   always_comb begin
      busy_d = busy_q;
      if (state_q == ST_IDLE && cmd_valid) begin
         busy_d = 8'(1) << cmd_dest;
      end else if (state_q == ST_WRITE) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_mask = busy_q;
`else
   assign busy_mask = 8'h00;
`endif

endmodule

// File: tb/tb_regfile_load_unit.sv
// ---------------------------------------------------------------------------
// tb_regfile_load_unit
// Bench for regfile_load_unit. A transaction-level reference model predicts
// each cycle's outputs from the accept cycle of the current load; a RAM model
// returns 16'hA000|addr only in the cycle the data is due, and a register file
// model applies the DUT's writes for a final content comparison.
// ---------------------------------------------------------------------------
module tb_regfile_load_unit;

   localparam int unsigned MEM_LAT = 1;
   localparam int          LAT     = int'(MEM_LAT);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_dest = '0;
   logic [7:0]  cmd_addr = '0;
   logic        mem_re;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata = '0;
   logic        write_enable;
   logic [2:0]  write_addr;
   logic [15:0] write_data;
   logic [7:0]  busy_mask;

   regfile_load_unit #(
      .DATA_W     (16),
      .REG_ADDR_W (3),
      .ADDR_W     (8),
      .MEM_LAT    (MEM_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_dest     (cmd_dest),
      .cmd_addr     (cmd_addr),
      .mem_re       (mem_re),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .busy_mask    (busy_mask)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int we_cnt = 0;

   // Reference model state: the load in flight, described by its accept cycle.
   bit          m_active = 1'b0;
   int          m_acc    = 0;
   logic [2:0]  m_dest   = '0;
   logic [7:0]  m_addr   = '0;
   logic [7:0]  e_mem_addr = '0;
   logic [2:0]  e_wa = '0;
   logic [15:0] e_wd = '0;

   // RAM model state and register files (DUT-driven and reference).
   int          ram_issue = -100;
   logic [7:0]  ram_addr  = '0;
   logic [15:0] rf     [8];
   logic [15:0] rf_ref [8];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: check outputs, play RAM/regfile, drive inputs, advance model.
   task automatic run_cycle(input bit r, input bit v, input logic [2:0] d, input logic [7:0] a);
      bit         exp_rdy, exp_re, exp_we;
      logic [7:0] exp_busy;
      @(posedge clk);
      #1;
      cyc++;
      if (m_active && cyc >= m_acc + LAT + 3) m_active = 1'b0;
      exp_rdy = !m_active;
      exp_re  = m_active && (cyc == m_acc + 1);
      exp_we  = m_active && (cyc == m_acc + LAT + 2);
      if (exp_re) e_mem_addr = m_addr;
      if (exp_we) begin
         e_wa = m_dest;
         e_wd = 16'hA000 | {8'h00, m_addr};
         rf_ref[m_dest] = e_wd;
      end
      exp_busy = 8'h00;
`ifdef LOAD_SCOREBOARD_EN
      if (m_active && cyc > m_acc) exp_busy = 8'(1) << m_dest;
`endif
      check_eq("cmd_ready",    32'(cmd_ready),    32'(exp_rdy));
      check_eq("mem_re",       32'(mem_re),       32'(exp_re));
      check_eq("mem_addr",     32'(mem_addr),     32'(e_mem_addr));
      check_eq("write_enable", 32'(write_enable), 32'(exp_we));
      check_eq("write_addr",   32'(write_addr),   32'(e_wa));
      check_eq("write_data",   32'(write_data),   32'(e_wd));
      check_eq("busy_mask",    32'(busy_mask),    32'(exp_busy));

      // Register file takes the write at the negedge of this cycle.
      if (write_enable === 1'b1) begin
         rf[write_addr] = write_data;
         we_cnt++;
      end
      // RAM: data valid only MEM_LAT cycles after the read strobe.
      if (mem_re === 1'b1) begin
         ram_issue = cyc;
         ram_addr  = mem_addr;
      end
      if (cyc == ram_issue + LAT) mem_rdata = 16'hA000 | {8'h00, ram_addr};
      else                        mem_rdata = {4'h5, 12'($urandom)};

      rst       = r;
      cmd_valid = v;
      cmd_dest  = d;
      cmd_addr  = a;

      if (r) begin
         m_active   = 1'b0;
         e_mem_addr = '0;
         e_wa       = '0;
         e_wd       = '0;
      end else if (!m_active && v) begin
         m_active = 1'b1;
         m_acc    = cyc;
         m_dest   = d;
         m_addr   = a;
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         rf[i]     = 16'h1110 + 16'(i);
         rf_ref[i] = 16'h1110 + 16'(i);
      end

      // Reset for two cycles, then idle.
      run_cycle(1'b1, 1'b0, 3'd0, 8'h00);
      run_cycle(1'b1, 1'b0, 3'd0, 8'h00);
      run_cycle(1'b0, 1'b0, 3'd0, 8'h00);

      // Single load dest=3 addr=0x4B.
      run_cycle(1'b0, 1'b1, 3'd3, 8'h4B);
      repeat (5) run_cycle(1'b0, 1'b0, 3'd0, 8'h00);
      check_eq("rf3_after_load", 32'(rf[3]), 32'h0000_A04B);

      // Valid held: second command waits for cmd_ready.
      run_cycle(1'b0, 1'b1, 3'd4, 8'h02);
      repeat (6) run_cycle(1'b0, 1'b1, 3'd5, 8'h07);
      repeat (6) run_cycle(1'b0, 1'b0, 3'd0, 8'h00);
      check_eq("write_pulses", 32'(we_cnt), 32'd3);
      check_eq("rf4_after_load", 32'(rf[4]), 32'h0000_A002);
      check_eq("rf5_after_load", 32'(rf[5]), 32'h0000_A007);

      // Reset during WAIT of a load to dest=6 drops the write.
      run_cycle(1'b0, 1'b1, 3'd6, 8'h33);
      run_cycle(1'b0, 1'b0, 3'd0, 8'h00);
      run_cycle(1'b1, 1'b0, 3'd0, 8'h00);
      repeat (6) run_cycle(1'b0, 1'b0, 3'd0, 8'h00);
      check_eq("rf6_kept", 32'(rf[6]), 32'h0000_1116);
      check_eq("write_pulses_after_rst", 32'(we_cnt), 32'd3);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         run_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                   3'($urandom), 8'($urandom));
      end
      repeat (MEM_LAT + 4) run_cycle(1'b0, 1'b0, 3'd0, 8'h00);

      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("rf_final[%0d]", i), 32'(rf[i]), 32'(rf_ref[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
